// File: rtl/mc_main_control.sv
// Multicycle MIPS main-control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional bne support is built when MC_MAIN_CONTROL_BNE_EN is defined.
module mc_main_control #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       illegal_op,
  output logic       bus_timeout,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_MAIN_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  state_t           state;
  state_t           next;
  logic [CNT_W-1:0] cnt;
  logic             is_mem;
  logic             timeout;
  logic             bad_op;
  logic             take_branch;
`ifdef MC_MAIN_CONTROL_BNE_EN
  logic             is_bne;
`endif

  assign is_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout = (MAX_WAIT != 0) && is_mem && !mem_ready && (cnt == LAST_WAIT);
  assign state_o = state;

`ifdef MC_MAIN_CONTROL_BNE_EN
  assign take_branch = is_bne ? ~zero : zero;
`else
  assign take_branch = zero;
`endif

  always_comb begin
    next   = FETCH;
    bad_op = 1'b0;
    case (state)
      FETCH:  next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = EXEC;
          OP_BEQ:       next = BRANCH;
`ifdef MC_MAIN_CONTROL_BNE_EN
          OP_BNE:       next = BRANCH;
`endif
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default: begin
            next   = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEMADR: next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next = mem_ready ? MEMWB : (timeout ? FETCH : MEMRD);
      MEMWR:  next = (mem_ready || timeout) ? FETCH : MEMWR;
      EXEC:   next = ALUWB;
      ADDIEX: next = ADDIWB;
      default: next = FETCH;
    endcase
  end

  // Strobes are Moore-decoded but gated by handshake, timeout and reset in the same cycle.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcen     = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = take_branch;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n || timeout) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
    end
    if (!rst_n) regwrite = 1'b0;
  end

  // Leaving a memory state always goes through mem_ready or timeout, so a plain
  // clear-on-anything-else also covers the clear-on-entry rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      cnt         <= '0;
      illegal_op  <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      state <= next;
      cnt   <= (is_mem && !mem_ready && !timeout) ? cnt + CNT_W'(1) : '0;
      if (bad_op)  illegal_op  <= 1'b1;
      if (timeout) bus_timeout <= 1'b1;
    end
  end

`ifdef MC_MAIN_CONTROL_BNE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               is_bne <= 1'b0;
    else if (state == DECODE) is_bne <= (opcode == OP_BNE);
  end
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: instruction-level reference model queues
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_mc_main_control;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       pcen, illegal_op, bus_timeout;
  logic [3:0] state_o;

  mc_main_control #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .illegal_op(illegal_op),
    .bus_timeout(bus_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [19:0] act;
  assign act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, pcen, illegal_op, bus_timeout, state_o};

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [19:0] q[$];
  bit          m_ill, m_bto, m_bne;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected output vector for one cycle, straight from the per-state output table.
  function automatic logic [19:0] exp_vec(input int s, input bit r, input bit z, input bit t);
    logic io, mw, ir, rd, mr, rw, sa, pe;
    logic [1:0] sb, ps, ao;
    {io, mw, ir, rd, mr, rw, sa, pe} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      0:  begin sb = 2'b01; ir = r; pe = r; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin io = 1; mw = !t; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = m_bne ? !z : z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {io, mw, ir, rd, mr, rw, sa, sb, ps, ao, pe, m_ill, m_bto, 4'(s)};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 bne, 7 illegal
  function automatic int kind(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 5;
`ifdef MC_MAIN_CONTROL_BNE_EN
      6'b000101: return 6;
`endif
      default:   return 7;
    endcase
  endfunction

  // Called at posedge+1: drive inputs, queue the expectation, advance one cycle.
  task automatic cyc(input int s, input bit r, input bit z, input bit t,
                     input bit set_ill, input bit set_bto);
    mem_ready = r;
    zero      = z;
    q.push_back(exp_vec(s, r, z, t));
    @(posedge clk); #1;
    if (set_ill) m_ill = 1'b1;
    if (set_bto) m_bto = 1'b1;
  endtask

  // Memory wait phase: w cycles of mem_ready=0 then ready, or a timeout first.
  task automatic mem_phase(input int s, input int w, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; ; i++) begin
      if (i < w) begin
        bit t;
        t = (i == MAXW - 1);
        cyc(s, 1'b0, rb(), t, 1'b0, t);
        if (t) begin
          timed_out = 1'b1;
          return;
        end
      end else begin
        cyc(s, 1'b1, rb(), 1'b0, 1'b0, 1'b0);
        return;
      end
    end
  endtask

  task automatic instr(input logic [5:0] op, input bit z, input int fw, input int mw);
    int k;
    bit to;
    opcode = op;
    k      = kind(op);
    for (int i = 0; i < fw; i++) begin
      bit t;
      t = ((i % MAXW) == MAXW - 1);
      cyc(0, 1'b0, rb(), t, 1'b0, t);
    end
    cyc(0, 1'b1, rb(), 1'b0, 1'b0, 1'b0);
    cyc(1, rb(), rb(), 1'b0, k == 7, 1'b0);
    m_bne = (k == 6);
    case (k)
      0: begin cyc(6, rb(), rb(), 0, 0, 0); cyc(7, rb(), rb(), 0, 0, 0); end
      1: begin
        cyc(2, rb(), rb(), 0, 0, 0);
        mem_phase(3, mw, to);
        if (!to) cyc(4, rb(), rb(), 0, 0, 0);
      end
      2: begin cyc(2, rb(), rb(), 0, 0, 0); mem_phase(5, mw, to); end
      3, 6: cyc(8, rb(), z, 0, 0, 0);
      4: begin cyc(9, rb(), rb(), 0, 0, 0); cyc(10, rb(), rb(), 0, 0, 0); end
      5: cyc(11, rb(), rb(), 0, 0, 0);
      default: ;
    endcase
    m_bne = 1'b0;
  endtask

  initial begin : monitor
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("cycle_st%0d", e[3:0]), 32'(act), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] ops [9];

  initial begin : stim
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b000010, 6'b000101, 6'b111111, 6'b000000};
    m_ill = 0; m_bto = 0; m_bne = 0;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0;
    #3;
    check("rst_state", 32'(state_o), 0);
    check("rst_strobes", 32'({irwrite, pcen, memwrite, regwrite}), 0);
    check("rst_flags", 32'({illegal_op, bus_timeout}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    instr(6'b000000, 1'b0, 0, 0);
    instr(6'b100011, 1'b0, 0, 3);
    instr(6'b000100, 1'b1, 0, 0);
    instr(6'b000100, 1'b0, 0, 0);
    instr(6'b111111, 1'b0, 0, 0);
    instr(6'b000010, 1'b0, 0, 0);
    instr(6'b101011, 1'b0, 0, 4);
    instr(6'b001000, 1'b0, 2, 0);
    instr(6'b000101, 1'b0, 0, 0);
    instr(6'b000101, 1'b1, 0, 0);
    instr(6'b100011, 1'b0, 1, 5);
    instr(6'b000000, 1'b0, 5, 0);
    instr(6'b101011, 1'b0, 0, 2);

    // Reset asserted in the middle of a store wait.
    opcode = 6'b101011;
    cyc(0, 1'b1, 1'b0, 0, 0, 0);
    cyc(1, 1'b0, 1'b0, 0, 0, 0);
    cyc(2, 1'b0, 1'b0, 0, 0, 0);
    mem_ready = 1'b0;
    #1;
    check("memwr_before_rst", 32'({state_o, memwrite}), 32'({4'd5, 1'b1}));
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("async_rst_state", 32'(state_o), 0);
    check("async_rst_strobes", 32'({memwrite, irwrite, pcen, regwrite}), 0);
    check("async_rst_flags", 32'({illegal_op, bus_timeout}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ill = 0; m_bto = 0;

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      op  = (sel == 9) ? 6'($urandom) : ops[sel];
      instr(op, rb(), $urandom_range(0, 5), $urandom_range(0, 5));
    end

    @(negedge clk); #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle MIPS main-control FSM. It sits directly upstream of alu_decoder and drives its aluop input.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Issues datapath mux selects and write strobes, and stalls on a memory-ready handshake.
- Sticky error flags cover illegal opcodes and memory timeouts.

Parameters:
- MAX_WAIT, 255: cycles to wait for mem_ready in a memory state before timeout; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register; stable from DECODE until return to FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  destination register: 1=rd, 0=rt
- memtoreg  out  1  writeback data: 1=data reg, 0=ALUOut
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0=PC, 1=rs
- alusrcb  out  2  ALU B: 00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
- pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- aluop  out  2  to alu_decoder: 00=add, 01=sub, 10=use funct
- pcen  out  1  PC write enable
- illegal_op  out  1  sticky flag: unknown opcode decoded
- bus_timeout  out  1  sticky flag: mem_ready wait exceeded MAX_WAIT
- state_o  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH next cycle with all strobes 0.
- Moore outputs decoded from state. Strobes are gated as listed below. Any output not listed for a state is 0.
- Reset:
  - Asynchronously forces state=FETCH, wait counter=0, illegal_op=0, bus_timeout=0.
  - While rst_n=0, memwrite, irwrite, regwrite and pcen are forced to 0.
  - Reset mid-instruction abandons that instruction with no partial writes.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00.
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH and set illegal_op.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR. Opcode is re-read here; it is stable.
- MEMRD: iord=1. Goes to MEMWB on mem_ready; otherwise waits.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR:
  - iord=1, memwrite=1, held for the whole wait.
  - Goes to FETCH on mem_ready.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Then FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - pcen=zero.
  - Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JUMP: pcsrc=10, pcen=1. Then FETCH.
- Latency with mem_ready tied to 1, counting FETCH through the last state:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - illegal opcode: 2 cycles
- Each additional mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and on mem_ready=1.
  - Increments each cycle spent in a memory state with mem_ready=0.
  - Timeout condition: MAX_WAIT!=0 and counter==MAX_WAIT-1 with mem_ready still 0.
  - On timeout: set bus_timeout, go to FETCH, and suppress all strobes in that cycle (memwrite=irwrite=pcen=0).
  - Simultaneous mem_ready=1 and timeout: mem_ready wins and the access completes normally.
- Sticky flags: illegal_op and bus_timeout clear only on reset. The FSM continues operating after either is set.

Optional Feature:
- Macro: MC_MAIN_CONTROL_BNE_EN.
- Defined:
  - Opcode 000101 (bne) decodes DECODE -> BRANCH.
  - A registered is_bne bit is captured in DECODE.
  - In BRANCH, pcen = is_bne ? ~zero : zero.
  - bne latency is 3 cycles.
- Undefined: 000101 is illegal (sets illegal_op, returns to FETCH), and no is_bne register is built.

Test Plan:
- Reset, then R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. aluop=10 in EXEC. regwrite=1 and regdst=1 only in ALUWB.
- lw (100011) with mem_ready=0 for 3 cycles in MEMRD, MAX_WAIT=255 -> 8-cycle instruction. iord=1 throughout MEMRD. regwrite=1 and memtoreg=1 in MEMWB only.
- beq (000100) with zero=1, then zero=0 -> pcen=1, aluop=01, pcsrc=01 in BRANCH for the first; pcen=0 for the second. No regwrite in either.
- Opcode 111111 -> DECODE returns to FETCH. illegal_op=1 and stays 1 through the following j (000010), which yields pcsrc=10 and pcen=1 in JUMP.
- MAX_WAIT=4, sw with mem_ready held 0 -> memwrite=1 for 3 MEMWR cycles, then 0 in the timeout cycle. bus_timeout=1 and state=FETCH next cycle.
- Assert rst_n=0 mid-MEMWR -> state_o=0, memwrite=0 immediately (asynchronous). Both flags 0. With MC_MAIN_CONTROL_BNE_EN defined, bne with zero=0 -> pcen=1.
